// File: rtl/multi_stage_buffer.sv
// Valid/ready FIFO buffer with G_DEPTH entries, registered handshake outputs,
// a fill-level count and a programmable almost-full flag.
module multi_stage_buffer #(
    parameter int G_DATA_SIZE   = 8,
    parameter int G_DEPTH       = 4,
    parameter int G_AFULL_LEVEL = 3
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic                           s_valid_i,
    output logic                           s_ready_o,
    input  logic [G_DATA_SIZE-1:0]         s_data_i,
    output logic                           m_valid_o,
    input  logic                           m_ready_i,
    output logic [G_DATA_SIZE-1:0]         m_data_o,
    output logic [$clog2(G_DEPTH+1)-1:0]   fill_o,
    output logic                           afull_o
);

    localparam int FW = $clog2(G_DEPTH + 1);
    localparam int PW = (G_DEPTH > 1) ? $clog2(G_DEPTH) : 1;

    logic [G_DATA_SIZE-1:0] mem_q [G_DEPTH];
    logic [PW-1:0]          wrPtr_q, wrPtr_d;
    logic [PW-1:0]          rdPtr_q, rdPtr_d;
    logic [FW-1:0]          fill_q, fill_d;
    logic                   sReady_q, sReady_d;
    logic                   mValid_q, mValid_d;
    logic                   afull_q, afull_d;
    logic                   push;
    logic                   pop;

    // Handshakes use only registered flags, so no input reaches an output combinationally.
    assign push = s_valid_i & sReady_q;
    assign pop  = mValid_q & m_ready_i;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        fill_d  = fill_q;
        if (push) begin
            wrPtr_d = (wrPtr_q == PW'(G_DEPTH - 1)) ? '0 : wrPtr_q + PW'(1);
        end
        if (pop) begin
            rdPtr_d = (rdPtr_q == PW'(G_DEPTH - 1)) ? '0 : rdPtr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   fill_d = fill_q + FW'(1);
            2'b01:   fill_d = fill_q - FW'(1);
            default: fill_d = fill_q;
        endcase
        // Status flags are derived from the post-edge fill so they are registered.
        sReady_d = (fill_d < FW'(G_DEPTH));
        mValid_d = (fill_d != '0);
        afull_d  = (fill_d >= FW'(G_AFULL_LEVEL));
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            fill_q   <= '0;
            sReady_q <= 1'b0;
            mValid_q <= 1'b0;
            afull_q  <= 1'b0;
        end else begin
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            fill_q   <= fill_d;
            sReady_q <= sReady_d;
            mValid_q <= mValid_d;
            afull_q  <= afull_d;
        end
    end

    // Storage carries no reset; entries are only observable once counted in fill.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wrPtr_q] <= s_data_i;
        end
    end

    assign s_ready_o = sReady_q;
    assign m_valid_o = mValid_q;
    assign m_data_o  = mem_q[rdPtr_q];
    assign fill_o    = fill_q;
    assign afull_o   = afull_q;

endmodule

// File: tb/tb_multi_stage_buffer.sv
// Directed bench for multi_stage_buffer: a depth-4 instance for the handshake,
// full/almost-full, wrap and reset cases, and a depth-3 instance for random stalls.
module tb_multi_stage_buffer;

    logic       clk = 1'b0;
    logic       rstn;

    logic       sValid, sReady, mValid, mReady, afull;
    logic [7:0] sData, mData;
    logic [2:0] fill;

    logic       sValidB, sReadyB, mValidB, mReadyB, afullB;
    logic [7:0] sDataB, mDataB;
    logic [1:0] fillB;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    multi_stage_buffer #(.G_DATA_SIZE(8), .G_DEPTH(4), .G_AFULL_LEVEL(3)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .s_valid_i(sValid), .s_ready_o(sReady), .s_data_i(sData),
        .m_valid_o(mValid), .m_ready_i(mReady), .m_data_o(mData),
        .fill_o(fill), .afull_o(afull)
    );

    multi_stage_buffer #(.G_DATA_SIZE(8), .G_DEPTH(3), .G_AFULL_LEVEL(3)) dut3 (
        .clk_i(clk), .rstn_i(rstn),
        .s_valid_i(sValidB), .s_ready_o(sReadyB), .s_data_i(sDataB),
        .m_valid_o(mValidB), .m_ready_i(mReadyB), .m_data_o(mDataB),
        .fill_o(fillB), .afull_o(afullB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
        sValid = v;
        sData  = d;
        mReady = r;
    endtask

    initial begin
        int  sent, recv, sentB, recvB;
        logic pushNow, popNow;

        rstn = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        sValidB = 1'b0; sDataB = 8'h00; mReadyB = 1'b0;
        tick(); tick();

        // 1. reset state and first push
        checkOutput("rst_sready", sReady, 0);
        checkOutput("rst_mvalid", mValid, 0);
        checkOutput("rst_fill",   fill,   0);
        checkOutput("rst_afull",  afull,  0);
        rstn = 1'b1;
        tick();
        checkOutput("first_sready", sReady, 1);
        applyStimulus(1'b1, 8'h11, 1'b0);
        tick();
        checkOutput("push1_mvalid", mValid, 1);
        checkOutput("push1_data",   mData,  8'h11);
        checkOutput("push1_fill",   fill,   1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        tick();
        checkOutput("pop1_fill",   fill,   0);
        checkOutput("pop1_mvalid", mValid, 0);

        // 2. fill to full
        applyStimulus(1'b1, 8'hA1, 1'b0); tick();
        applyStimulus(1'b1, 8'hA2, 1'b0); tick();
        checkOutput("fill2_afull", afull, 0);
        applyStimulus(1'b1, 8'hA3, 1'b0); tick();
        checkOutput("fill3_afull", afull, 1);
        checkOutput("fill3_sready", sReady, 1);
        applyStimulus(1'b1, 8'hA4, 1'b0); tick();
        checkOutput("full_fill",   fill,   4);
        checkOutput("full_sready", sReady, 0);
        checkOutput("full_head",   mData,  8'hA1);
        applyStimulus(1'b1, 8'hA5, 1'b0); tick();
        checkOutput("full_hold_fill", fill,  4);
        checkOutput("full_hold_head", mData, 8'hA1);

        // 3. pop from full does not admit a push in the same cycle
        applyStimulus(1'b1, 8'hA5, 1'b1); tick();
        checkOutput("fullpop_fill",   fill,   3);
        checkOutput("fullpop_sready", sReady, 1);
        checkOutput("fullpop_head",   mData,  8'hA2);
        applyStimulus(1'b1, 8'hA5, 1'b0); tick();
        checkOutput("a5_fill",   fill,   4);
        checkOutput("a5_sready", sReady, 0);
        applyStimulus(1'b0, 8'h00, 1'b1); tick(); tick();
        checkOutput("drain_fill",  fill,  2);
        checkOutput("drain_head",  mData, 8'hA4);
        checkOutput("drain_afull", afull, 0);

        // 4. simultaneous push/pop, then continuous streaming across the wrap
        applyStimulus(1'b1, 8'h55, 1'b1); tick();
        checkOutput("pushpop_fill", fill,  2);
        checkOutput("pushpop_head", mData, 8'hA5);
        applyStimulus(1'b0, 8'h00, 1'b1); tick();
        checkOutput("pushpop_next", mData, 8'h55);
        tick();
        checkOutput("empty_mvalid", mValid, 0);

        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 40 && recv < 10; cyc++) begin
            applyStimulus(sent < 10, 8'(sent), 1'b1);
            pushNow = sValid & sReady;
            popNow  = mValid & mReady;
            if (popNow) begin
                checkOutput("stream_data", mData, 32'(8'(recv)));
                recv++;
            end
            tick();
            if (pushNow) sent++;
        end
        checkOutput("stream_count", recv, 10);
        applyStimulus(1'b0, 8'h00, 1'b0);
        tick();
        checkOutput("stream_empty", fill, 0);

        // 5. asynchronous reset between edges
        applyStimulus(1'b1, 8'h31, 1'b0); tick();
        applyStimulus(1'b1, 8'h32, 1'b0); tick();
        applyStimulus(1'b1, 8'h33, 1'b0); tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("prerst_fill", fill, 3);
        #3 rstn = 1'b0;
        #1;
        checkOutput("arst_fill",   fill,   0);
        checkOutput("arst_mvalid", mValid, 0);
        checkOutput("arst_sready", sReady, 0);
        checkOutput("arst_afull",  afull,  0);
        tick();
        rstn = 1'b1;
        tick();
        checkOutput("rel_sready", sReady, 1);
        checkOutput("rel_mvalid", mValid, 0);
        checkOutput("rel_fill",   fill,   0);

        // 6. depth-3 instance, random stalls on both sides
        sentB = 0;
        recvB = 0;
        for (int cyc = 0; cyc < 300 && recvB < 5; cyc++) begin
            if (!sValidB) sValidB = (sentB < 5) && ($urandom_range(0, 1) == 1);
            sDataB  = 8'(8'hC0 + sentB);
            mReadyB = ($urandom_range(0, 2) != 0);
            pushNow = sValidB & sReadyB;
            popNow  = mValidB & mReadyB;
            if (popNow) begin
                checkOutput("d3_order", mDataB, 32'(8'(8'hC0 + recvB)));
                recvB++;
            end
            tick();
            if (pushNow) begin
                sentB++;
                sValidB = 1'b0;
            end
            checkOutput("d3_fillmax", 32'(fillB <= 2'd3 && fillB <= 2'(sentB - recvB)), 1);
        end
        checkOutput("d3_count", recvB, 5);
        sValidB = 1'b0;
        mReadyB = 1'b0;
        tick();
        checkOutput("d3_empty", fillB, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
